// File: rtl/servo_slew_if.sv
// Bus and servo-facing signal bundle for the servo slew-rate limiter.
// The master drives the bus; the slave (servo_slew) returns read data and position status.
interface servo_slew_if;
  logic [7:0] din;
  logic [7:0] address;
  logic       w_en;
  logic       r_en;
  logic [7:0] dout;
  logic [7:0] position;
  logic       position_strobe;
  logic       busy;
  logic       done_irq;

  modport master (
    output din, address, w_en, r_en,
    input  dout, position, position_strobe, busy, done_irq
  );

  modport slave (
    input  din, address, w_en, r_en,
    output dout, position, position_strobe, busy, done_irq
  );
endinterface

// File: rtl/servo_slew.sv
// Memory-mapped slew-rate limiter: walks an 8-bit servo position toward a written
// target in bounded steps, one step per programmable millisecond interval.
module servo_slew #(
  parameter logic [7:0] SERVO_SLEW_ADDRESS = 8'h00,
  parameter int         CLK_FREQ           = 16000000
) (
  input  logic         clk,
  input  logic         rst,
  servo_slew_if.slave  bus
);

  localparam int DATA_W = 8;
  localparam int MS_DIV = CLK_FREQ / 1000;
  localparam int PW     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(MS_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  logic [DATA_W-1:0] position_q, position_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic [DATA_W-1:0] rate_q, rate_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic [DATA_W-1:0] ivl_q, ivl_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [1:0]        state_q, state_d;
  logic              done_q, done_d;
  logic              strobe_q, strobe_d;
  logic              jump_q, jump_d;

  logic [DATA_W-1:0] offset;
  logic              wr_target, wr_rate, wr_step, wr_position, rd_status;
  logic              ms_tick;
  logic [DATA_W-1:0] delta;

  // Step size limited to the remaining distance; signed 9-bit difference cannot wrap.
  function automatic logic [DATA_W-1:0] step_delta(input logic [DATA_W-1:0] step,
                                                   input logic [DATA_W-1:0] tgt,
                                                   input logic [DATA_W-1:0] pos);
    logic signed [DATA_W:0] diff;
    logic        [DATA_W:0] mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, pos});
    mag  = diff[DATA_W] ? unsigned'(-diff) : unsigned'(diff);
    step_delta = ({1'b0, step} < mag) ? step : mag[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] step_toward(input logic [DATA_W-1:0] pos,
                                                    input logic [DATA_W-1:0] tgt,
                                                    input logic [DATA_W-1:0] dlt);
    step_toward = (tgt > pos) ? pos + dlt : pos - dlt;
  endfunction

  assign offset      = bus.address - SERVO_SLEW_ADDRESS;
  assign wr_target   = bus.w_en && (offset == 8'd0);
  assign wr_rate     = bus.w_en && (offset == 8'd1);
  assign wr_step     = bus.w_en && (offset == 8'd2);
  assign wr_position = bus.w_en && (offset == 8'd3);
  assign rd_status   = bus.r_en && (offset == 8'd4);
  assign ms_tick     = (presc_q == PRESC_MAX);
  assign delta       = step_delta(step_q, target_q, position_q);

  always_comb begin
    position_d = position_q;
    target_d   = target_q;
    rate_d     = rate_q;
    step_d     = step_q;
    ivl_d      = ivl_q;
    dout_d     = dout_q;
    state_d    = state_q;
    done_d     = done_q;
    jump_d     = 1'b0;
    presc_d    = ms_tick ? '0 : presc_q + 1'b1;

    if (bus.r_en) begin
      case (offset)
        8'd0:    dout_d = target_q;
        8'd1:    dout_d = rate_q;
        8'd2:    dout_d = step_q;
        8'd3:    dout_d = position_q;
        8'd4:    dout_d = {6'd0, done_q, (state_q != S_IDLE)};
        default: dout_d = '0;
      endcase
    end

    // Clear first so any completion in the same cycle overrides it.
    if (rd_status) done_d = 1'b0;

    // A RATE==0 target write lands one edge after the write edge.
    if (jump_q) begin
      position_d = target_q;
      done_d     = 1'b1;
    end

    if (wr_target) target_d = bus.din;

    case (state_q)
      S_IDLE: begin
        if (wr_target) begin
          if (bus.din == position_d) begin
            done_d = 1'b1;
          end else if (rate_q == '0) begin
            jump_d = 1'b1;
          end else begin
            ivl_d   = rate_q;
            presc_d = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (wr_target && (bus.din == position_q)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (ivl_q == '0) begin
          state_d = S_STEP;
        end else if (ms_tick) begin
          ivl_d = ivl_q - 8'd1;
          if (ivl_q == 8'd1) state_d = S_STEP;
        end
      end
      S_STEP: begin
        position_d = step_toward(position_q, target_q, delta);
        if (position_d == target_d) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          ivl_d   = rate_q;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_rate) rate_d = bus.din;
    if (wr_step) step_d = (bus.din == '0) ? 8'd1 : bus.din;
    // A forced position overrides any step or pending jump in the same cycle.
    if (wr_position) begin
      position_d = bus.din;
      target_d   = bus.din;
      state_d    = S_IDLE;
      jump_d     = 1'b0;
    end

    strobe_d = (position_d != position_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      position_q <= '0;
      target_q   <= '0;
      rate_q     <= '0;
      step_q     <= 8'd1;
      ivl_q      <= '0;
      dout_q     <= '0;
      presc_q    <= '0;
      state_q    <= S_IDLE;
      done_q     <= 1'b0;
      strobe_q   <= 1'b0;
      jump_q     <= 1'b0;
    end else begin
      position_q <= position_d;
      target_q   <= target_d;
      rate_q     <= rate_d;
      step_q     <= step_d;
      ivl_q      <= ivl_d;
      dout_q     <= dout_d;
      presc_q    <= presc_d;
      state_q    <= state_d;
      done_q     <= done_d;
      strobe_q   <= strobe_d;
      jump_q     <= jump_d;
    end
  end

  assign bus.dout            = dout_q;
  assign bus.position        = position_q;
  assign bus.position_strobe = strobe_q;
  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done_irq        = done_q;

endmodule

// File: tb/tb_servo_slew.sv
// Directed bench for servo_slew at 16 clocks per millisecond.
module tb_servo_slew;
  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  servo_slew_if bus_if ();

  servo_slew #(.SERVO_SLEW_ADDRESS(8'h00), .CLK_FREQ(16000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic bus_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    bus_if.address = addr;
    bus_if.din     = data;
    bus_if.w_en    = 1'b1;
    @(negedge clk);
    bus_if.w_en    = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] addr, output logic [7:0] data);
    @(negedge clk);
    bus_if.address = addr;
    bus_if.r_en    = 1'b1;
    @(negedge clk);
    bus_if.r_en    = 1'b0;
    data = bus_if.dout;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus_if.position !== 8'd0) $display("FAIL rst_position: got %0d want 0", bus_if.position); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.done_irq !== 1'b0) $display("FAIL rst_done: got %b want 0", bus_if.done_irq); else pass_cnt++;
    total_cnt++; if (bus_if.dout !== 8'd0) $display("FAIL rst_dout: got %0d want 0", bus_if.dout); else pass_cnt++;
    total_cnt++; if (bus_if.position_strobe !== 1'b0) $display("FAIL rst_strobe: got %b want 0", bus_if.position_strobe); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [7:0] rd;
    bus_write(8'h01, 8'd2);
    bus_write(8'h02, 8'd10);
    bus_write(8'h00, 8'd35);
    bus_read(8'h01, rd);
    repeat (4) @(negedge clk);
    total_cnt++; if (bus_if.busy !== 1'b1) $display("FAIL midwait_busy: got %b want 1", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.dout !== 8'd2) $display("FAIL midwait_rate_rd: got %0d want 2", bus_if.dout); else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL arst_busy: got %b want 0", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.dout !== 8'd0) $display("FAIL arst_dout: got %0d want 0", bus_if.dout); else pass_cnt++;
    total_cnt++; if (bus_if.position !== 8'd0) $display("FAIL arst_position: got %0d want 0", bus_if.position); else pass_cnt++;
    total_cnt++; if (bus_if.done_irq !== 1'b0) $display("FAIL arst_done: got %b want 0", bus_if.done_irq); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    bus_read(8'h01, rd);
    total_cnt++; if (rd !== 8'd0) $display("FAIL arst_rate: got %0d want 0", rd); else pass_cnt++;
    bus_read(8'h02, rd);
    total_cnt++; if (rd !== 8'd1) $display("FAIL arst_step: got %0d want 1", rd); else pass_cnt++;
  endtask

  task automatic test_stepping();
    logic [7:0] exp_pos [4];
    logic [7:0] got_pos [4];
    int         got_cyc [4];
    int         n;
    logic       busy_last, done_last, done_prev;
    exp_pos = '{8'd10, 8'd20, 8'd30, 8'd35};
    n = 0; busy_last = 1'b1; done_last = 1'b0; done_prev = 1'b1;
    bus_write(8'h01, 8'd2);
    bus_write(8'h02, 8'd10);
    bus_write(8'h00, 8'd35);
    for (int cyc = 1; cyc <= 180; cyc++) begin
      @(negedge clk);
      if (bus_if.position_strobe === 1'b1) begin
        if (n < 4) begin
          got_pos[n] = bus_if.position;
          got_cyc[n] = cyc;
          if (n == 2) done_prev = bus_if.done_irq;
          if (n == 3) begin busy_last = bus_if.busy; done_last = bus_if.done_irq; end
        end
        n++;
      end
    end
    total_cnt++; if (n !== 4) $display("FAIL step_count: got %0d want 4", n); else pass_cnt++;
    if (n >= 4) begin
      for (int i = 0; i < 4; i++) begin
        total_cnt++;
        if (got_pos[i] !== exp_pos[i]) $display("FAIL step_pos%0d: got %0d want %0d", i, got_pos[i], exp_pos[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if (got_cyc[0] < 31 || got_cyc[0] > 33) $display("FAIL step_first_latency: got %0d want 31..33", got_cyc[0]);
      else pass_cnt++;
      for (int i = 1; i < 4; i++) begin
        total_cnt++;
        if ((got_cyc[i] - got_cyc[i-1]) < 31 || (got_cyc[i] - got_cyc[i-1]) > 34)
          $display("FAIL step_spacing%0d: got %0d want 31..34", i, got_cyc[i] - got_cyc[i-1]);
        else pass_cnt++;
      end
      total_cnt++; if (done_prev !== 1'b0) $display("FAIL step_done_early: got %b want 0", done_prev); else pass_cnt++;
      total_cnt++; if (busy_last !== 1'b0) $display("FAIL step_busy_final: got %b want 0", busy_last); else pass_cnt++;
      total_cnt++; if (done_last !== 1'b1) $display("FAIL step_done_final: got %b want 1", done_last); else pass_cnt++;
    end
  endtask

  task automatic test_jump();
    logic [7:0] rd;
    int         strobes;
    bus_write(8'h01, 8'd0);
    bus_write(8'h00, 8'd200);
    total_cnt++; if (bus_if.position !== 8'd35) $display("FAIL jump_before: got %0d want 35", bus_if.position); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus_if.position !== 8'd200) $display("FAIL jump_position: got %0d want 200", bus_if.position); else pass_cnt++;
    strobes = (bus_if.position_strobe === 1'b1) ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (bus_if.position_strobe === 1'b1) strobes++;
    end
    total_cnt++; if (strobes !== 1) $display("FAIL jump_strobes: got %0d want 1", strobes); else pass_cnt++;
    bus_read(8'h04, rd);
    total_cnt++; if (rd !== 8'h02) $display("FAIL jump_status1: got %h want 02", rd); else pass_cnt++;
    bus_read(8'h04, rd);
    total_cnt++; if (rd !== 8'h00) $display("FAIL jump_status2: got %h want 00", rd); else pass_cnt++;
  endtask

  task automatic test_downward();
    logic [7:0] exp_pos [3];
    logic [7:0] got_pos [3];
    int         got_cyc [3];
    int         n;
    logic [7:0] rd;
    exp_pos = '{8'd99, 8'd98, 8'd97};
    n = 0;
    bus_write(8'h03, 8'd100);
    bus_write(8'h02, 8'd0);
    bus_read(8'h02, rd);
    total_cnt++; if (rd !== 8'd1) $display("FAIL down_step_rd: got %0d want 1", rd); else pass_cnt++;
    bus_write(8'h01, 8'd1);
    bus_write(8'h00, 8'd97);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      if (bus_if.position_strobe === 1'b1) begin
        if (n < 3) begin got_pos[n] = bus_if.position; got_cyc[n] = cyc; end
        n++;
      end
    end
    total_cnt++; if (n !== 3) $display("FAIL down_count: got %0d want 3", n); else pass_cnt++;
    if (n >= 3) begin
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (got_pos[i] !== exp_pos[i]) $display("FAIL down_pos%0d: got %0d want %0d", i, got_pos[i], exp_pos[i]);
        else pass_cnt++;
      end
      total_cnt++;
      if ((got_cyc[2] - got_cyc[1]) < 15 || (got_cyc[2] - got_cyc[1]) > 18)
        $display("FAIL down_spacing: got %0d want 15..18", got_cyc[2] - got_cyc[1]);
      else pass_cnt++;
    end
    total_cnt++; if (bus_if.done_irq !== 1'b1) $display("FAIL down_done: got %b want 1", bus_if.done_irq); else pass_cnt++;
  endtask

  task automatic test_retarget();
    logic [7:0] rd;
    int         seen;
    bus_write(8'h03, 8'd0);
    bus_read(8'h04, rd);
    bus_write(8'h02, 8'd20);
    bus_write(8'h01, 8'd1);
    bus_write(8'h00, 8'd50);
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen == 0; cyc++) begin
      @(negedge clk);
      if (bus_if.position_strobe === 1'b1) seen = 1;
    end
    total_cnt++; if (bus_if.position !== 8'd20) $display("FAIL retgt_first: got %0d want 20", bus_if.position); else pass_cnt++;
    bus_write(8'h00, 8'd10);
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen == 0; cyc++) begin
      @(negedge clk);
      if (bus_if.position_strobe === 1'b1) seen = 1;
    end
    total_cnt++; if (bus_if.position !== 8'd10) $display("FAIL retgt_second: got %0d want 10", bus_if.position); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL retgt_busy: got %b want 0", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.done_irq !== 1'b1) $display("FAIL retgt_done: got %b want 1", bus_if.done_irq); else pass_cnt++;
  endtask

  task automatic test_position_abort();
    logic [7:0] rd;
    bus_read(8'h04, rd);
    bus_write(8'h01, 8'd2);
    bus_write(8'h02, 8'd5);
    bus_write(8'h00, 8'd60);
    repeat (10) @(negedge clk);
    total_cnt++; if (bus_if.busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", bus_if.busy); else pass_cnt++;
    bus_write(8'h03, 8'd77);
    total_cnt++; if (bus_if.position !== 8'd77) $display("FAIL abort_position: got %0d want 77", bus_if.position); else pass_cnt++;
    total_cnt++; if (bus_if.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus_if.busy); else pass_cnt++;
    total_cnt++; if (bus_if.done_irq !== 1'b0) $display("FAIL abort_done: got %b want 0", bus_if.done_irq); else pass_cnt++;
    bus_read(8'h00, rd);
    total_cnt++; if (rd !== 8'd77) $display("FAIL abort_target_rd: got %0d want 77", rd); else pass_cnt++;
    bus_read(8'h05, rd);
    total_cnt++; if (rd !== 8'd0) $display("FAIL undecoded_rd: got %0d want 0", rd); else pass_cnt++;
    repeat (80) @(negedge clk);
    total_cnt++; if (bus_if.position !== 8'd77) $display("FAIL abort_hold: got %0d want 77", bus_if.position); else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    rst            = 1'b1;
    bus_if.din     = 8'd0;
    bus_if.address = 8'd0;
    bus_if.w_en    = 1'b0;
    bus_if.r_en    = 1'b0;
    test_reset();
    test_reset_mid_wait();
    test_stepping();
    test_jump();
    test_downward();
    test_retarget();
    test_position_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/servo_slew.md
# servo_slew

Memory-mapped slew-rate limiter that sits directly upstream of the servo PWM controller. Software writes a target angle, a step size and a step interval. The block walks an 8-bit position output toward the target in bounded steps, one step per interval. It flags completion so the servo does not slam between angles. The `position` output is wired to the servo controller's angle register (or written into it through the bus glue). It uses the same 8-bit address/data bus as the other peripherals.

## Interface
- `SERVO_SLEW_ADDRESS`, 8'h00 — base address; the block decodes base+0 .. base+4.
- `CLK_FREQ`, 16000000 — clk frequency in Hz; the millisecond tick divisor is `CLK_FREQ/1000` clocks.

Ports:
- `clk`  in  1  — system clock; all state changes on its rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `din`  in  8  — bus write data.
- `address`  in  8  — bus address.
- `w_en`  in  1  — write strobe, sampled on the clk edge.
- `r_en`  in  1  — read strobe, sampled on the clk edge.
- `dout`  out  8  — registered read data.
- `position`  out  8  — current commanded angle, feeds the servo controller.
- `position_strobe`  out  1  — one-cycle pulse in the cycle `position` takes a new value.
- `busy`  out  1  — high while the state is not IDLE.
- `done_irq`  out  1  — level; equals the sticky DONE flag.

## Operation
- Registers (offset from base):
  - +0 TARGET (R/W). A write starts a move.
  - +1 RATE (R/W). Step interval in ms ticks; 0 means jump immediately.
  - +2 STEP (R/W). Step size; a written 0 is stored as 1.
  - +3 POSITION (R/W). A write forces position and target to `din`, aborts any move and goes to IDLE; it does not set DONE.
  - +4 STATUS (R). bit0 = busy, bit1 = DONE, other bits 0. A read clears DONE.
- Reset values: position 0, TARGET 0, RATE 0, STEP 1, DONE 0, state IDLE, prescaler 0, interval counter 0, `dout` 0, `position_strobe` 0, `busy` 0, `done_irq` 0.
- Reads:
  - `r_en` with a decoded address loads `dout` with that register on the next edge.
  - Any non-decoded address loads `dout` with 0.
  - `r_en` low on a decoded address holds `dout`.
- Millisecond prescaler:
  - Free-running; counts 0 .. `CLK_FREQ/1000`−1.
  - Emits a one-cycle `ms_tick` at the wrap.
  - Reset to 0 on every TARGET write that leaves IDLE, so the first interval is a full RATE ms.
- State machine:
  - IDLE, TARGET write with `din` == position: DONE set, no strobe.
  - IDLE, TARGET write with `din` ≠ position and RATE == 0: position ← `din` on the next edge, strobe, DONE set, stay IDLE.
  - IDLE, TARGET write with `din` ≠ position and RATE ≠ 0: load the interval counter with RATE, go to WAIT.
  - WAIT: decrement the interval counter on each `ms_tick`. When it reaches 0, go to STEP.
  - STEP (exactly one cycle):
    - delta = min(STEP, |TARGET − position|), computed in 9 bits; no wrap-around is possible.
    - position moves by delta toward TARGET, strobe.
    - If position now equals TARGET: DONE set, go to IDLE. Otherwise reload the interval counter with RATE and go to WAIT.
- Retargeting mid-move:
  - A TARGET write in WAIT updates TARGET without restarting the interval.
  - If the new TARGET equals position, go to IDLE with DONE set.
  - The direction is re-evaluated at the next STEP.
- RATE or STEP writes mid-move take effect at the next interval reload or at the next STEP, respectively.

## Timing
- Register write to readback: write at edge N; a read issued at edge N+1 returns the new value on `dout` after edge N+1.
- Read latency is 1 clock.
- RATE = 0 jump: `position` and `position_strobe` change on the edge after the TARGET write edge.
- Stepping cadence: the first step lands exactly RATE×`CLK_FREQ/1000` clocks (±1) after the TARGET write. Later steps follow at the same period plus 1 clock for the STEP state.
- `position_strobe` is high for exactly one clock per change and never when the value is unchanged.
- Simultaneous events:
  - POSITION write wins over a STEP in the same cycle.
  - A DONE set wins over a STATUS-read clear in the same cycle.
  - A TARGET write in the STEP cycle is taken; the step uses the old TARGET, and completion is then re-checked against the new TARGET.
- Asynchronous `rst` mid-move immediately returns every register and output to its reset value.

## Test plan
- Reset with `rst` pulsed mid-WAIT -> `position` = 0, `busy` = 0, `done_irq` = 0, `dout` = 0 immediately; reading RATE/STEP returns 0 and 1.
- `CLK_FREQ` = 16000 (16 clks/ms), RATE = 2, STEP = 10, TARGET = 35 from 0 -> position goes 10, 20, 30, 35 at ~32-clock spacing. There are four strobes, `done_irq` rises with the final step, and `busy` falls in the same cycle.
- RATE = 0, TARGET = 200 -> `position` = 200 one clock after the write; a single strobe; STATUS read returns 8'h02, then a second read returns 8'h00.
- Downward move: position 100, STEP = 0 (stored 1), RATE = 1, TARGET = 97 -> 99, 98, 97 at 1 ms spacing; STEP readback = 1.
- Retarget mid-move: from 0 toward 50 (STEP = 20), write TARGET = 10 after the first step (position 20) -> next step gives 10, then IDLE with DONE set.
- POSITION write of 77 during WAIT -> position = 77, TARGET readback = 77, `busy` = 0, DONE unchanged; a read at offset 8'h05 returns 0.
